alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler_if.sv | 41 ++++
 rtl/alu_scheduler.sv | 140 ++++++++++++++
 tb/tb_alu_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_scheduler_if.sv
// Request/response and shared-ALU signal bundle for alu_scheduler.
// Latency: none, wires only.
// Backpressure: requesters hold req/op/a/b until ack; ALU results are sampled by the scheduler.
interface alu_scheduler_if;
  logic        req0;
  logic        req1;
  logic [6:0]  op0;
  logic [6:0]  op1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        ack0;
  logic        ack1;
  logic        done0;
  logic        done1;
  logic [31:0] res;
  logic        flag;
  logic        err;
  logic        busy;
  logic [6:0]  alu_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_en;
  logic [31:0] alu_c;
  logic        alu_flag;

  // Requester and ALU side
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_c, alu_flag,
    input  ack0, ack1, done0, done1, res, flag, err, busy,
           alu_instr, alu_a, alu_b, alu_en
  );

  // Scheduler side
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_c, alu_flag,
    output ack0, ack1, done0, done1, res, flag, err, busy,
           alu_instr, alu_a, alu_b, alu_en
  );
endinterface

// File: rtl/alu_scheduler.sv
// Two-requester scheduler sharing one ALU, round-robin on ties, IDLE/EXEC/RESP FSM.
// Latency: accept at cycle T gives done in cycle T+HOLD+1 (T+1 for illegal opcodes).
// Backpressure: ack stays low while busy; requesters hold req and operands until acked.
module alu_scheduler #(
  parameter int HOLD = 1
) (
  input logic            clock,
  input logic            resetn,
  alu_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Final value of the EXEC cycle counter (HOLD is 1..4)
  localparam logic [1:0] LAST_CNT = 2'(HOLD - 1);

  state_t      state_q;
  state_t      state_d;
  logic [6:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        gid_q;
  logic [1:0]  cnt_q;
  logic [31:0] res_q;
  logic        flag_q;
  logic        err_q;
  logic        last_q;   // requester granted most recently; resets to 1 so requester 0 wins the first tie

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [6:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_legal;
  logic        exec_last;
  logic        op_is_cmp;

  // Arbitration: only in IDLE and never while reset is applied; ties go to the requester not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && resetn) begin
      if (bus.req0 && bus.req1) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = bus.req0;
        grant1 = bus.req1;
      end
    end
  end

  assign accept    = grant0 | grant1;
  assign sel_op    = grant1 ? bus.op1 : bus.op0;
  assign sel_a     = grant1 ? bus.a1  : bus.a0;
  assign sel_b     = grant1 ? bus.b1  : bus.b0;
  assign sel_legal = (sel_op <= 7'd14);
  assign exec_last = (state_q == EXEC) && (cnt_q == LAST_CNT);
  assign op_is_cmp = (op_q >= 7'd8) && (op_q <= 7'd13);

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = sel_legal ? EXEC : RESP;
      EXEC:    if (exec_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Operand latch, EXEC counter, result capture and round-robin pointer
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      gid_q  <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            gid_q <= grant1;
            cnt_q <= '0;
            // Illegal opcodes skip the ALU and report immediately
            if (!sel_legal) begin
              res_q  <= '0;
              flag_q <= 1'b0;
              err_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt_q == LAST_CNT) begin
            res_q  <= bus.alu_c;
            flag_q <= op_is_cmp & bus.alu_flag;
            err_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP:    last_q <= gid_q;
        default: ;
      endcase
    end
  end

  assign bus.ack0      = grant0;
  assign bus.ack1      = grant1;
  assign bus.done0     = (state_q == RESP) && !gid_q;
  assign bus.done1     = (state_q == RESP) && gid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.alu_en    = (state_q == EXEC);
  assign bus.alu_instr = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.res       = res_q;
  assign bus.flag      = flag_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: directed scenarios plus a randomized run against a cycle-level model.
// Latency: n/a.
// Backpressure: requesters hold requests until acked, and sometimes withdraw them while the block is busy.
module tb_alu_scheduler;

  logic clock;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  alu_scheduler_if bus1 ();
  alu_scheduler_if bus3 ();

  alu_scheduler #(.HOLD(1)) dut1 (.clock(clock), .resetn(resetn), .bus(bus1.slave));
  alu_scheduler #(.HOLD(3)) dut3 (.clock(clock), .resetn(resetn), .bus(bus3.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: result per opcode
  function automatic logic [31:0] alu_res(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      7'd0:                                  return a + b;
      7'd1:                                  return a - b;
      7'd2:                                  return a << b[4:0];
      7'd3:                                  return a >> b[4:0];
      7'd4, 7'd7:                            return a;
      7'd5, 7'd6:                            return b;
      7'd8, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13: return a - b;
      7'd14:                                 return a;
      default:                               return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Behavioural ALU: flag is meaningful only for compares; other opcodes return 1 so forcing to 0 is visible
  function automatic logic alu_flg(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      7'd8:    return a == b;
      7'd9:    return a != b;
      7'd10:   return a < b;
      7'd11:   return a >= b;
      7'd12:   return $signed(a) < $signed(b);
      7'd13:   return $signed(a) >= $signed(b);
      default: return 1'b1;
    endcase
  endfunction

  assign bus1.alu_c    = alu_res(bus1.alu_instr, bus1.alu_a, bus1.alu_b);
  assign bus1.alu_flag = alu_flg(bus1.alu_instr, bus1.alu_a, bus1.alu_b);
  assign bus3.alu_c    = alu_res(bus3.alu_instr, bus3.alu_a, bus3.alu_b);
  assign bus3.alu_flag = alu_flg(bus3.alu_instr, bus3.alu_a, bus3.alu_b);

  task automatic clear_inputs();
    bus1.req0 = 0; bus1.req1 = 0; bus1.op0 = 0; bus1.op1 = 0;
    bus1.a0 = 0; bus1.b0 = 0; bus1.a1 = 0; bus1.b1 = 0;
    bus3.req0 = 0; bus3.req1 = 0; bus3.op0 = 0; bus3.op1 = 0;
    bus3.a0 = 0; bus3.b0 = 0; bus3.a1 = 0; bus3.b1 = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 with reset released
  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    clear_inputs();
    #2 resetn = 1'b0;
    bus1.req0 = 1; bus1.req1 = 1;
    @(negedge clock);
    checks++; if (bus1.ack0 !== 1'b0 || bus1.ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack got=%0b%0b exp=00", bus1.ack0, bus1.ack1); end
    checks++; if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b/%0b exp=0/0", bus1.busy, bus3.busy); end
    checks++; if (bus1.alu_en !== 1'b0 || bus3.alu_en !== 1'b0) begin errors++; $display("FAIL reset_alu_en got=%0b/%0b exp=0/0", bus1.alu_en, bus3.alu_en); end
    checks++; if (bus1.done0 !== 1'b0 || bus1.done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b%0b exp=00", bus1.done0, bus1.done1); end
    checks++; if (bus1.res !== 32'd0 || bus1.flag !== 1'b0 || bus1.err !== 1'b0) begin errors++; $display("FAIL reset_result got res=%h flag=%0b err=%0b exp 0/0/0", bus1.res, bus1.flag, bus1.err); end
    checks++; if (bus1.alu_instr !== 7'd0 || bus1.alu_a !== 32'd0 || bus1.alu_b !== 32'd0) begin errors++; $display("FAIL reset_operands got=%h/%h/%h exp 0", bus1.alu_instr, bus1.alu_a, bus1.alu_b); end
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    checks++; if (bus1.ack0 !== 1'b1 || bus1.ack1 !== 1'b0) begin errors++; $display("FAIL reset_first_tie got ack0=%0b ack1=%0b exp 1/0", bus1.ack0, bus1.ack1); end
  endtask

  task automatic test_basic();
    do_reset();
    bus1.req0 = 1; bus1.op0 = 7'd0; bus1.a0 = 5; bus1.b0 = 7;
    @(negedge clock);
    checks++; if (bus1.ack0 !== 1'b1 || bus1.ack1 !== 1'b0) begin errors++; $display("FAIL basic_ack got=%0b%0b exp ack0=1 ack1=0", bus1.ack0, bus1.ack1); end
    next_cycle();
    bus1.req0 = 0;
    @(negedge clock);
    checks++; if (bus1.alu_en !== 1'b1 || bus1.busy !== 1'b1 || bus1.ack0 !== 1'b0) begin errors++; $display("FAIL basic_exec got en=%0b busy=%0b ack0=%0b exp 1/1/0", bus1.alu_en, bus1.busy, bus1.ack0); end
    checks++; if (bus1.alu_instr !== 7'd0 || bus1.alu_a !== 32'd5 || bus1.alu_b !== 32'd7) begin errors++; $display("FAIL basic_operands got=%0d/%0d/%0d exp 0/5/7", bus1.alu_instr, bus1.alu_a, bus1.alu_b); end
    next_cycle();
    @(negedge clock);
    checks++; if (bus1.alu_en !== 1'b0 || bus1.done0 !== 1'b1 || bus1.done1 !== 1'b0) begin errors++; $display("FAIL basic_done got en=%0b done0=%0b done1=%0b exp 0/1/0", bus1.alu_en, bus1.done0, bus1.done1); end
    checks++; if (bus1.res !== 32'd12 || bus1.flag !== 1'b0 || bus1.err !== 1'b0) begin errors++; $display("FAIL basic_result got res=%0d flag=%0b err=%0b exp 12/0/0", bus1.res, bus1.flag, bus1.err); end
    next_cycle();
    @(negedge clock);
    checks++; if (bus1.done0 !== 1'b0 || bus1.busy !== 1'b0 || bus1.res !== 32'd12) begin errors++; $display("FAIL basic_after got done0=%0b busy=%0b res=%0d exp 0/0/12", bus1.done0, bus1.busy, bus1.res); end
  endtask

  // Runs right after test_basic without reset so res starts at 12
  task automatic test_illegal();
    next_cycle();
    bus1.req1 = 1; bus1.op1 = 7'd20; bus1.a1 = 32'h55; bus1.b1 = 32'h66;
    @(negedge clock);
    checks++; if (bus1.ack1 !== 1'b1 || bus1.ack0 !== 1'b0) begin errors++; $display("FAIL illegal_ack got=%0b%0b exp ack0=0 ack1=1", bus1.ack0, bus1.ack1); end
    next_cycle();
    bus1.req1 = 0;
    @(negedge clock);
    checks++; if (bus1.alu_en !== 1'b0 || bus1.done1 !== 1'b1) begin errors++; $display("FAIL illegal_done got en=%0b done1=%0b exp 0/1", bus1.alu_en, bus1.done1); end
    checks++; if (bus1.err !== 1'b1 || bus1.res !== 32'd0 || bus1.flag !== 1'b0) begin errors++; $display("FAIL illegal_result got err=%0b res=%h flag=%0b exp 1/0/0", bus1.err, bus1.res, bus1.flag); end
    next_cycle();
    @(negedge clock);
    checks++; if (bus1.done1 !== 1'b0 || bus1.err !== 1'b1 || bus1.alu_en !== 1'b0) begin errors++; $display("FAIL illegal_hold got done1=%0b err=%0b en=%0b exp 0/1/0", bus1.done1, bus1.err, bus1.alu_en); end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int both_cnt = 0;
    int n_done0 = 0;
    int n_done1 = 0;
    do_reset();
    bus1.req0 = 1; bus1.op0 = 7'd1; bus1.a0 = 9;  bus1.b0 = 4;
    bus1.req1 = 1; bus1.op1 = 7'd1; bus1.a1 = 20; bus1.b1 = 3;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (bus1.ack0 && bus1.ack1) both_cnt++;
      if (bus1.ack0) grants.push_back(0);
      if (bus1.ack1) grants.push_back(1);
      if (bus1.done0) begin
        n_done0++;
        checks++; if (bus1.res !== 32'd5) begin errors++; $display("FAIL rr_res0 got=%0d exp=5", bus1.res); end
      end
      if (bus1.done1) begin
        n_done1++;
        checks++; if (bus1.res !== 32'd17) begin errors++; $display("FAIL rr_res1 got=%0d exp=17", bus1.res); end
      end
      next_cycle();
    end
    clear_inputs();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rr_both_acks got=%0d cycles exp=0", both_cnt); end
    checks++;
    if (grants.size() < 4) begin errors++; $display("FAIL rr_grant_count got=%0d exp>=4", grants.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (grants[i] !== i % 2) begin errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], i % 2); end
      end
    end
    checks++; if (n_done0 < 2 || n_done1 < 2) begin errors++; $display("FAIL rr_dones got=%0d/%0d exp>=2/2", n_done0, n_done1); end
  endtask

  task automatic test_hold3();
    do_reset();
    bus3.req0 = 1; bus3.op0 = 7'd8; bus3.a0 = 32'h1234; bus3.b0 = 32'h1234;
    @(negedge clock);
    checks++; if (bus3.ack0 !== 1'b1) begin errors++; $display("FAIL hold3_ack got=%0b exp=1", bus3.ack0); end
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      bus3.req0 = 0;
      @(negedge clock);
      checks++; if (bus3.alu_en !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL hold3_en cycle=%0d got=%0b exp=%0b", k, bus3.alu_en, (k >= 1 && k <= 3)); end
      checks++; if (bus3.done0 !== (k == 4)) begin errors++; $display("FAIL hold3_done cycle=%0d got=%0b exp=%0b", k, bus3.done0, (k == 4)); end
      if (k == 4) begin
        checks++; if (bus3.flag !== 1'b1 || bus3.err !== 1'b0 || bus3.res !== 32'd0) begin errors++; $display("FAIL hold3_result got flag=%0b err=%0b res=%h exp 1/0/0", bus3.flag, bus3.err, bus3.res); end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    int n_done0 = 0;
    int n_done1 = 0;
    do_reset();
    bus3.req0 = 1; bus3.op0 = 7'd0; bus3.a0 = 1; bus3.b0 = 2;
    @(negedge clock);
    checks++; if (bus3.ack0 !== 1'b1) begin errors++; $display("FAIL rst_exec_ack0 got=%0b exp=1", bus3.ack0); end
    next_cycle();
    bus3.req0 = 0;
    bus3.req1 = 1; bus3.op1 = 7'd0; bus3.a1 = 3; bus3.b1 = 4;
    @(negedge clock);
    checks++; if (bus3.alu_en !== 1'b1) begin errors++; $display("FAIL rst_exec_en got=%0b exp=1", bus3.alu_en); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus3.alu_en !== 1'b0 || bus3.busy !== 1'b0 || bus3.ack1 !== 1'b0) begin errors++; $display("FAIL rst_exec_drop got en=%0b busy=%0b ack1=%0b exp 0/0/0", bus3.alu_en, bus3.busy, bus3.ack1); end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    checks++; if (bus3.ack1 !== 1'b1 || bus3.ack0 !== 1'b0) begin errors++; $display("FAIL rst_exec_resume got ack0=%0b ack1=%0b exp 0/1", bus3.ack0, bus3.ack1); end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      bus3.req1 = 0;
      @(negedge clock);
      if (bus3.done0) n_done0++;
      if (bus3.done1) n_done1++;
    end
    checks++; if (n_done0 !== 0 || n_done1 !== 1) begin errors++; $display("FAIL rst_exec_dones got done0=%0d done1=%0d exp 0/1", n_done0, n_done1); end
    // Both requesters held across reset: requester 0 goes first
    next_cycle();
    resetn = 1'b0;
    bus3.req0 = 1; bus3.req1 = 1;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    checks++; if (bus3.ack0 !== 1'b1 || bus3.ack1 !== 1'b0) begin errors++; $display("FAIL rst_both_first got ack0=%0b ack1=%0b exp 1/0", bus3.ack0, bus3.ack1); end
    clear_inputs();
  endtask

  task automatic test_busy_drop();
    int stray = 0;
    do_reset();
    bus1.req1 = 1; bus1.op1 = 7'd0; bus1.a1 = 10; bus1.b1 = 20;
    @(negedge clock);
    checks++; if (bus1.ack1 !== 1'b1) begin errors++; $display("FAIL drop_ack1 got=%0b exp=1", bus1.ack1); end
    next_cycle();
    bus1.req1 = 0;
    bus1.req0 = 1; bus1.op0 = 7'd0; bus1.a0 = 1; bus1.b0 = 1;
    @(negedge clock);
    checks++; if (bus1.ack0 !== 1'b0 || bus1.alu_a !== 32'd10) begin errors++; $display("FAIL drop_busy got ack0=%0b alu_a=%0d exp 0/10", bus1.ack0, bus1.alu_a); end
    next_cycle();
    bus1.req0 = 0;
    @(negedge clock);
    checks++; if (bus1.done1 !== 1'b1 || bus1.done0 !== 1'b0 || bus1.res !== 32'd30) begin errors++; $display("FAIL drop_done got done1=%0b done0=%0b res=%0d exp 1/0/30", bus1.done1, bus1.done0, bus1.res); end
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clock);
      if (bus1.done0 || bus1.ack0 || bus1.busy || bus1.res !== 32'd30) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL drop_after got=%0d disturbed cycles exp=0", stray); end
  endtask

  // Randomized traffic on the HOLD=1 instance against a cycle-level model
  task automatic test_random(input int n_cycles);
    localparam int H = 1;
    bit          pend [2];
    logic [6:0]  p_op [2];
    logic [31:0] p_a  [2];
    logic [31:0] p_b  [2];
    int          fav = 0;
    int          next_free = 0;
    int          acc_cyc = -10;
    int          done_cyc = -10;
    bit          in_flight = 0;
    int          f_id = 0;
    logic [6:0]  f_op = 0;
    logic [31:0] f_a = 0;
    logic [31:0] f_b = 0;
    bit          f_legal = 0;
    int          accepted = 0;
    int          completed = 0;
    int          g;
    bit          idle;
    bit          e_ack0, e_ack1, e_en;
    logic [31:0] e_res;
    logic        e_flag;
    pend[0] = 0; pend[1] = 0;
    do_reset();
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      idle = (cyc >= next_free);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && cyc < n_cycles - 40 && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          p_op[i] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(15, 127)) : 7'($urandom_range(0, 14));
          p_a[i]  = $urandom;
          p_b[i]  = $urandom;
        end else if (pend[i] && !idle && $urandom_range(0, 9) == 0) begin
          pend[i] = 0;
        end
      end
      bus1.req0 = pend[0]; bus1.op0 = p_op[0]; bus1.a0 = p_a[0]; bus1.b0 = p_b[0];
      bus1.req1 = pend[1]; bus1.op1 = p_op[1]; bus1.a1 = p_a[1]; bus1.b1 = p_b[1];
      @(negedge clock);
      g = -1;
      if (idle && (pend[0] || pend[1])) g = (pend[0] && pend[1]) ? fav : (pend[0] ? 0 : 1);
      e_ack0 = (g == 0);
      e_ack1 = (g == 1);
      e_en   = in_flight && f_legal && cyc > acc_cyc && cyc <= acc_cyc + H;
      checks++; if (bus1.ack0 !== e_ack0 || bus1.ack1 !== e_ack1) begin errors++; $display("FAIL rand_ack cyc=%0d got=%0b%0b exp=%0b%0b", cyc, bus1.ack1, bus1.ack0, e_ack1, e_ack0); end
      checks++; if (bus1.alu_en !== e_en || bus1.busy !== !idle) begin errors++; $display("FAIL rand_ctrl cyc=%0d got en=%0b busy=%0b exp %0b/%0b", cyc, bus1.alu_en, bus1.busy, e_en, !idle); end
      if (in_flight && cyc == done_cyc) begin
        e_res  = f_legal ? alu_res(f_op, f_a, f_b) : 32'd0;
        e_flag = (f_legal && f_op >= 8 && f_op <= 13) ? alu_flg(f_op, f_a, f_b) : 1'b0;
        checks++; if (bus1.done0 !== (f_id == 0) || bus1.done1 !== (f_id == 1)) begin errors++; $display("FAIL rand_done cyc=%0d got=%0b%0b exp id=%0d", cyc, bus1.done1, bus1.done0, f_id); end
        checks++; if (bus1.res !== e_res || bus1.flag !== e_flag || bus1.err !== !f_legal) begin errors++; $display("FAIL rand_result op=%0d got res=%h flag=%0b err=%0b exp %h/%0b/%0b", f_op, bus1.res, bus1.flag, bus1.err, e_res, e_flag, !f_legal); end
        in_flight = 0;
        completed++;
      end else begin
        checks++; if (bus1.done0 !== 1'b0 || bus1.done1 !== 1'b0) begin errors++; $display("FAIL rand_stray_done cyc=%0d got=%0b%0b exp=00", cyc, bus1.done1, bus1.done0); end
      end
      if (g >= 0) begin
        in_flight = 1;
        acc_cyc   = cyc;
        f_id      = g;
        f_op      = p_op[g];
        f_a       = p_a[g];
        f_b       = p_b[g];
        f_legal   = (p_op[g] <= 7'd14);
        done_cyc  = cyc + (f_legal ? H + 1 : 1);
        next_free = done_cyc + 1;
        fav       = 1 - g;
        pend[g]   = 0;
        accepted++;
      end
      next_cycle();
    end
    clear_inputs();
    checks++; if (completed !== accepted || accepted < 20) begin errors++; $display("FAIL rand_totals got completed=%0d accepted=%0d exp equal and >=20", completed, accepted); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_round_robin();
    test_hold3();
    test_reset_mid_exec();
    test_busy_drop();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
